// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: decode-side handshake, redirect input, and instruction-memory port.
// The master modport is the sequencer; the slave modport is the surrounding core/memory.
interface fetch_sequencer_if;
    localparam int unsigned XLEN = 16;

    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_data;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] pc_plus2;
    logic            halted;

    modport master (
        input  stall, redirect, redirect_pc, imem_ready, imem_data,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus2, halted
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ready, imem_data,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus2, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request, 2-entry instruction queue,
// branch redirect flush, and HLT drain/halt handling.
module fetch_sequencer (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);
    localparam int unsigned XLEN  = 16;
    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Each entry carries its own pc+2 so the head outputs come straight from flops.
    typedef struct packed {
        logic [XLEN-1:0] word;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc2;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{word: '0, pc: '0, pc2: XLEN'(2)};

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic            outstanding;
    logic            halted;
    entry_t          q [DEPTH];
    logic [1:0]      q_valid;

    logic [1:0] count;
    logic [1:0] count_next;
    logic       push;
    logic       pop;
    logic       hlt_data;
    logic       hlt_head;
    logic       launch;
    entry_t     new_entry;

    always_comb begin
        count      = 2'(q_valid[0]) + 2'(q_valid[1]);
        pop        = q_valid[0] & ~bus.stall;
        push       = outstanding & bus.imem_ready & ~bus.redirect;
        hlt_data   = (bus.imem_data[XLEN-1:XLEN-4] == 4'hF);
        hlt_head   = (q[0].word[XLEN-1:XLEN-4] == 4'hF);
        count_next = count + 2'(push) - 2'(pop);
        launch     = (state == FETCH) && !(push && hlt_data) && !bus.redirect
                     && (!outstanding || bus.imem_ready) && (count_next < 2'd2);
        new_entry  = '{word: bus.imem_data, pc: fetch_pc, pc2: fetch_pc + XLEN'(2)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= '0;
            outstanding <= 1'b0;
            halted      <= 1'b0;
            q_valid     <= '0;
            q[0]        <= RESET_ENTRY;
            q[1]        <= RESET_ENTRY;
        end else if (state != HALTED) begin
            if (bus.redirect) begin
                state       <= FETCH;
                fetch_pc    <= bus.redirect_pc & ~XLEN'(1);
                outstanding <= 1'b0;
                q_valid     <= '0;
            end else begin
                outstanding <= launch | (outstanding & ~bus.imem_ready);
                if (push) begin
                    fetch_pc <= fetch_pc + XLEN'(2);
                end

                // Shift on pop; a push lands in the slot just past the surviving entries.
                if (pop) begin
                    q[0] <= q[1];
                end
                if (push) begin
                    if (count_next == 2'd2) begin
                        q[1] <= new_entry;
                    end else begin
                        q[0] <= new_entry;
                    end
                end
                q_valid <= (count_next == 2'd2) ? 2'b11 :
                           (count_next == 2'd1) ? 2'b01 : 2'b00;

                case (state)
                    FETCH: begin
                        if (push && hlt_data) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (pop && hlt_head) begin
                            state   <= HALTED;
                            halted  <= 1'b1;
                            q_valid <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.imem_req   = outstanding;
    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = q_valid[0];
    assign bus.inst       = q[0].word;
    assign bus.inst_pc    = q[0].pc;
    assign bus.pc_plus2   = q[0].pc2;
    assign bus.halted     = halted;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random stimulus,
// all compared against a queue-based transaction model of the fetch rules.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] word;
        logic [15:0] pc;
    } ent_t;

    // Model: mode 0 = fetching, 1 = draining after HLT, 2 = halted.
    ent_t        mq [$];
    logic [15:0] m_pc;
    logic        m_out;
    int          m_mode;
    bit          m_after_rst;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        ent_t hd;
        ent_t e;
        bit   popped;
        bit   got;
        m_after_rst = 1'b0;
        if (rst) begin
            mq.delete();
            m_pc        = 16'h0000;
            m_out       = 1'b0;
            m_mode      = 0;
            m_after_rst = 1'b1;
        end else if (m_mode != 2) begin
            if (bus.redirect) begin
                mq.delete();
                m_out  = 1'b0;
                m_pc   = bus.redirect_pc & 16'hFFFE;
                m_mode = 0;
            end else begin
                popped = (mq.size() > 0) && !bus.stall;
                got    = m_out && bus.imem_ready;
                if (popped) begin
                    hd = mq.pop_front();
                    if (m_mode == 1 && hd.word[15:12] == 4'hF) begin
                        m_mode = 2;
                        mq.delete();
                    end
                end
                if (got) begin
                    e.word = bus.imem_data;
                    e.pc   = m_pc;
                    mq.push_back(e);
                    m_pc  = m_pc + 16'd2;
                    m_out = 1'b0;
                    if (bus.imem_data[15:12] == 4'hF) m_mode = 1;
                end
                if (m_mode == 0 && !m_out && mq.size() < 2) m_out = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_req",   16'(bus.imem_req),   16'(m_out));
        check_eq("imem_addr",  bus.imem_addr,       m_pc);
        check_eq("inst_valid", 16'(bus.inst_valid), 16'(mq.size() > 0));
        check_eq("halted",     16'(bus.halted),     16'(m_mode == 2));
        if (mq.size() > 0) begin
            check_eq("inst",     bus.inst,     mq[0].word);
            check_eq("inst_pc",  bus.inst_pc,  mq[0].pc);
            check_eq("pc_plus2", bus.pc_plus2, mq[0].pc + 16'd2);
        end else if (m_after_rst) begin
            check_eq("rst_inst",     bus.inst,     16'h0000);
            check_eq("rst_inst_pc",  bus.inst_pc,  16'h0000);
            check_eq("rst_pc_plus2", bus.pc_plus2, 16'h0002);
        end
    endtask

    // Drive one cycle's inputs (called at a negedge), advance model at posedge, check at next negedge.
    task automatic cycle(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                         input logic rdy, input logic [15:0] dat);
        rst             = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_ready  = rdy;
        bus.imem_data   = dat;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Memory answers any pending model request this cycle.
    task automatic mem(input logic s, input logic [15:0] dat);
        cycle(1'b0, s, 1'b0, 16'h0000, m_out, dat);
    endtask

    initial begin
        logic        r;
        logic        s;
        logic        rd;
        logic        rdy;
        logic [15:0] rpc;
        logic [15:0] dat;

        // Reset, including a stray imem_ready while in reset.
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);

        // Two back-to-back fetches, then stall until the queue fills and release.
        mem(1'b0, 16'h1000);
        mem(1'b0, 16'h2000);
        mem(1'b1, 16'h3000);
        mem(1'b1, 16'h3100);
        mem(1'b1, 16'h3200);
        mem(1'b0, 16'h4000);
        mem(1'b0, 16'h4100);

        // Redirect coinciding with imem_ready: data discarded, refetch at 0x0040.
        cycle(1'b0, 1'b0, 1'b1, 16'h0041, m_out, 16'h5555);
        mem(1'b0, 16'h6000);
        mem(1'b0, 16'h6100);

        // HLT at 0x0006: drain, halt on pop, then redirect and memory activity ignored.
        cycle(1'b0, 1'b1, 1'b1, 16'h0006, 1'b0, 16'h0000);
        mem(1'b1, 16'h0000);
        mem(1'b1, 16'hF000);
        mem(1'b1, 16'h0000);
        mem(1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 16'h0200, 1'b1, 16'h1111);
        mem(1'b0, 16'h2222);

        // Reset out of HALTED; HLT squashed by a redirect before it is popped.
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        mem(1'b1, 16'h0000);
        mem(1'b1, 16'hF000);
        mem(1'b1, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000);
        mem(1'b0, 16'h0000);
        mem(1'b0, 16'h7000);

        // Wraparound at the top of the address space.
        cycle(1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0000);
        mem(1'b1, 16'h0000);
        mem(1'b1, 16'h1111);
        mem(1'b1, 16'h2222);
        mem(1'b0, 16'h0000);
        mem(1'b0, 16'h0000);

        // Random traffic with occasional redirects, HLTs and resets.
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 199) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = 16'hFFFE;
                1:       rpc = 16'hFFFF;
                default: rpc = 16'($urandom);
            endcase
            rdy = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            dat = 16'($urandom);
            dat[15:12] = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            cycle(r, s, rd, rpc, rdy, dat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
